// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// ALU operation codes, FSM states and special-case result constants.
package mul_div_unit_pkg;

  localparam int MD_WIDTH = 32;

  // M-extension codes as produced by the ALU control decoder
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Special-case operands and results that bypass the iterative loop
  localparam logic [MD_WIDTH-1:0] MD_OVF_DIVIDEND = {1'b1, {(MD_WIDTH-1){1'b0}}};
  localparam logic [MD_WIDTH-1:0] MD_OVF_DIVISOR  = {MD_WIDTH{1'b1}};
  localparam logic [MD_WIDTH-1:0] MD_DIVZERO_QUOT = {MD_WIDTH{1'b1}};
  localparam logic [MD_WIDTH-1:0] MD_OVF_REM      = {MD_WIDTH{1'b0}};

  // True for the eight codes the unit is allowed to accept
  function automatic logic isMulDivOp(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational two's-complement negate for sign handling around the loop.
// In wide mode the whole 2W vector is one number (negated by neg_hi_i);
// otherwise the upper and lower W-bit halves are negated independently.
module md_sign_fix
  import mul_div_unit_pkg::*;
#(
  parameter int W = MD_WIDTH
) (
  input  logic [2*W-1:0] val_i,
  input  logic           wide_i,
  input  logic           neg_hi_i,
  input  logic           neg_lo_i,
  output logic [2*W-1:0] val_o
);

  // Conditional negation, either across the full vector or per half
  always_comb begin
    val_o = val_i;
    if (wide_i) begin
      if (neg_hi_i) val_o = -val_i;
    end else begin
      if (neg_hi_i) val_o[2*W-1:W] = -val_i[2*W-1:W];
      if (neg_lo_i) val_o[W-1:0]   = -val_i[W-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle over
// 32 CALC cycles on unsigned magnitudes, followed by a FIX cycle that
// restores the sign and picks the requested word.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = MD_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      operation,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [4:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic            sign_q, remSign_q;
  logic            busy_q, busy_d, done_q, done_d;

  logic            accept, isDivIn, signA, signB, divZero, overflow, special;
  logic [XLEN-1:0] specialRes, absA, absB, finalRes;
  logic [XLEN:0]   mulSum, divTrial;
  logic            divGe, opIsMul, selLow;
  logic [2*XLEN-1:0] fixed;

  assign isDivIn = (operation >= ALU_DIV) && (operation <= ALU_REMU);
  assign accept  = (state_q == MD_IDLE) && start && !flush && isMulDivOp(operation);

  // Decode operand signedness and detect results that skip the loop
  always_comb begin
    signA      = 1'b0;
    signB      = 1'b0;
    specialRes = '0;
    case (operation)
      ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
        signA = 1'b1;
        signB = 1'b1;
      end
      ALU_MULHSU: signA = 1'b1;
      default: ;
    endcase
    divZero  = isDivIn && (src_b == '0);
    overflow = ((operation == ALU_DIV) || (operation == ALU_REM)) &&
               (src_a == MD_OVF_DIVIDEND) && (src_b == MD_OVF_DIVISOR);
    special  = divZero || overflow;
    if (divZero)
      specialRes = ((operation == ALU_DIV) || (operation == ALU_DIVU)) ? MD_DIVZERO_QUOT : src_a;
    else if (overflow)
      specialRes = (operation == ALU_DIV) ? MD_OVF_DIVIDEND : MD_OVF_REM;
  end

  md_sign_fix #(.W(XLEN)) u_absFix (
    .val_i    ({src_a, src_b}),
    .wide_i   (1'b0),
    .neg_hi_i (signA & src_a[XLEN-1]),
    .neg_lo_i (signB & src_b[XLEN-1]),
    .val_o    ({absA, absB})
  );

  // One shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    divTrial = {rem_q, quo_q[XLEN-1]} - {1'b0, b_q};
    divGe    = !divTrial[XLEN];
  end

  assign opIsMul = (op_q <= ALU_MULHU);
  assign selLow  = (op_q == ALU_MUL) || (op_q == ALU_DIV) || (op_q == ALU_DIVU);

  md_sign_fix #(.W(XLEN)) u_resFix (
    .val_i    (opIsMul ? acc_q : {rem_q, quo_q}),
    .wide_i   (opIsMul),
    .neg_hi_i (opIsMul ? sign_q : remSign_q),
    .neg_lo_i (sign_q),
    .val_o    (fixed)
  );

  assign finalRes = selLow ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];

  // FSM state register plus iteration counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; flush wins over every other transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: if (accept) state_d = special ? MD_DONE : MD_CALC;
        MD_CALC: if (count_q == 5'd31) state_d = MD_FIX;
        MD_FIX:  state_d = MD_DONE;
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they register cleanly
  always_comb begin
    busy_d  = (state_d != MD_IDLE);
    done_d  = (state_d == MD_DONE);
    count_d = ((state_q == MD_CALC) && (state_d == MD_CALC)) ? count_q + 5'd1 : 5'd0;
  end

  // Operand latch, iterative datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      sign_q    <= 1'b0;
      remSign_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= operation;
      a_q       <= absA;
      b_q       <= absB;
      acc_q     <= {{XLEN{1'b0}}, absB};
      rem_q     <= '0;
      quo_q     <= absA;
      sign_q    <= (signA & src_a[XLEN-1]) ^ (signB & src_b[XLEN-1]);
      remSign_q <= signA & src_a[XLEN-1];
      if (special) result_q <= specialRes;
    end else if (state_q == MD_CALC) begin
      if (opIsMul) begin
        acc_q <= {mulSum, acc_q[XLEN-1:1]};
      end else begin
        rem_q <= divGe ? divTrial[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_q <= {quo_q[XLEN-2:0], divGe};
      end
    end else if ((state_q == MD_FIX) && !flush) begin
      result_q <= finalRes;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table for results and latency,
// plus hand-written sequences for ignored starts, flush and mid-run reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  operation = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[16];

  mul_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Single comparison with failure report
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present a one-cycle start; returns at the negedge after the sampling edge
  task automatic startOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; operation = op; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cycle n=1 is the cycle right after the start edge
  task automatic waitDone(input int nStart, output logic [31:0] res, output int lat, output logic busyOk);
    lat = 0; busyOk = 1'b1; res = result;
    for (int n = nStart; n <= 80; n++) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      if (done === 1'b1) begin
        lat = n; res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output logic busyOk);
    startOp(op, a, b);
    waitDone(1, res, lat, busyOk);
  endtask

  initial begin
    logic [31:0] res, prior;
    int          lat;
    logic        busyOk, seen;

    vecs[0]  = '{"mul_7x-3",      ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{"mulhu_max",     ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[2]  = '{"mulhsu_-1x2",   ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[3]  = '{"div_-7/2",      ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[4]  = '{"rem_-7%2",      ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[5]  = '{"divu_by0",      ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{"rem_by0",       ALU_REM,    32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[7]  = '{"div_ovf",       ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{"rem_ovf",       ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[9]  = '{"mulh_min2",     ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[10] = '{"mul_-1x-1",     ALU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 34};
    vecs[11] = '{"div_7/-2",      ALU_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[12] = '{"rem_7%-2",      ALU_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[13] = '{"remu_100%7",    ALU_REMU,   32'd100,        32'd7,         32'd2,         34};
    vecs[14] = '{"divu_max/1",    ALU_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};
    vecs[15] = '{"mulh_-7x3",     ALU_MULH,   32'hFFFF_FFF9,  32'd3,         32'hFFFF_FFFF, 34};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busyOk);
      checkOutput({vecs[i].name, "_result"}, res, vecs[i].expRes);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].expLat);
      checkOutput({vecs[i].name, "_busy"}, {31'd0, busyOk}, 32'd1);
    end

    // Non-M code is ignored
    prior = result;
    startOp(5'd0, 32'd3, 32'd4);
    seen = 1'b0;
    repeat (4) begin
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("nonM_busy", {31'd0, seen}, 32'd0);
    checkOutput("nonM_result", result, prior);

    // Start while busy is ignored
    startOp(ALU_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; operation = ALU_MUL; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, res, lat, busyOk);
    checkOutput("busyStart_result", res, 32'd14);
    checkOutput("busyStart_latency", lat, 34);

    // Start presented during DONE is ignored
    start = 1'b1; operation = ALU_MUL; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("doneStart_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("doneStart_result", result, 32'd14);

    // Flush at count 10
    startOp(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checkOutput("flush_noDone", {31'd0, seen}, 32'd0);
    checkOutput("flush_result", result, 32'd14);

    // Reset at count 20
    startOp(ALU_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midReset_done", {31'd0, done}, 32'd0);
    checkOutput("midReset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(ALU_DIVU, 32'd100, 32'd7, res, lat, busyOk);
    checkOutput("afterReset_result", res, 32'd14);
    checkOutput("afterReset_latency", lat, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the ALU control decoder: it consumes the 5-bit ALU operation code, alongside the ALU, whenever that code selects an M-extension operation. It computes one result over many cycles and raises `busy` so the core holds the PC and register write-back until `done`. A radix-2 shift-add or shift-subtract loop performs one bit per cycle, with sign handling before and after the loop.

## Interface
- `XLEN`, 32: operand and result width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `flush`  in  1  abort any operation in progress; no `done` is produced.
- `operation`  in  5  ALU operation code from ALU control. Only the eight M codes are accepted.
- `src_a`  in  XLEN  rs1 value (multiplicand or dividend).
- `src_b`  in  XLEN  rs2 value (multiplier or divisor).
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  final value; held until the next accepted start.

## Operation
- Accepted operation codes are `ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU` (codes 16–23).
- A start is accepted only when all of these hold: state is IDLE, `start`=1, `flush`=0, and `operation` is one of the eight M codes. Any other start is ignored, produces no `busy`, and leaves `result` unchanged.
- On accept, the unit latches the operation, takes absolute values of signed operands, and records the result sign.
  - MULHSU: treat `src_a` as signed and `src_b` as unsigned.
  - Quotient sign is `a[31]^b[31]`.
  - Remainder sign is `a[31]`.
- FSM states:
  - IDLE → CALC on a normal accept.
  - IDLE → DONE on a special-case accept.
  - CALC → CALC while `count`<31.
  - CALC → FIX when `count`=31.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `flush`.
- CALC: a 5-bit `count` runs from 0 to 31, one partial-product or restoring-division step per cycle.
  - Multiply uses a 64-bit accumulator.
  - Divide uses a 32-bit remainder and a 32-bit quotient register.
- FIX: apply sign correction (two's complement negate when the recorded sign is 1), then select the low or high word, or the quotient or remainder.
- Special cases skip CALC and FIX:
  - Divide by zero: DIV and DIVU return `32'hFFFFFFFF`; REM and REMU return `src_a`.
  - Signed overflow (`src_a`=`32'h80000000`, `src_b`=`32'hFFFFFFFF`): DIV returns `32'h80000000`; REM returns 0.
- Width rules:
  - All intermediates are unsigned magnitudes.
  - Negating `32'h80000000` yields itself, which is the correct magnitude for unsigned treatment.
  - The MULH result is bits 63:32 of the corrected 64-bit product.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state=IDLE, `count`=0.
- Start sampled at edge E0 (normal path):
  - `busy`=1 from E0 through E34.
  - CALC occupies the cycles after E0 through E31.
  - FIX follows E32.
  - DONE follows E33: `done`=1 and `result` valid in the cycle after E33, i.e. 34 cycles after start.
  - IDLE is reached at E34.
- Special case: DONE is entered at E0, so `done` is high in the cycle immediately after E0; `busy` is high in that cycle only.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- A back-to-back start is legal in the same cycle IDLE is re-entered. A start presented during DONE is ignored.
- `flush`:
  - Takes effect at the next edge: state=IDLE, `busy`=0, `done`=0, `result` unchanged.
  - If `flush` arrives in DONE, `done` still completes in that cycle. Flush does not retract a result already presented.
- Asserting `rst_n` low mid-operation immediately clears all outputs to their reset values.

## Structure
- Shared `parameters.v`:
  - `ALU_MUL`…`ALU_REMU` operation codes.
  - FSM state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE`.
  - Special-case constants.
- One natural sub-module: `md_sign_fix`, a combinational negate/select for pre-loop absolute value and post-loop correction. It is instantiated twice.
- The FSM, counter and datapath registers stay in `mul_div_unit`.

## Test plan
- MUL with `src_a`=7, `src_b`=-3: `busy` for 34 cycles, then `done` with `result`=`32'hFFFFFFEB`.
- MULHU with `src_a`=`src_b`=`32'hFFFFFFFF`: `result`=`32'hFFFFFFFE`. MULHSU with `src_a`=-1, `src_b`=2: `result`=`32'hFFFFFFFF`.
- DIV with `src_a`=-7, `src_b`=2: quotient -3 (`32'hFFFFFFFD`). REM with the same operands: -1.
- Special cases:
  - DIVU with divisor 0: `32'hFFFFFFFF`.
  - REM with divisor 0: returns `src_a`.
  - DIV of `32'h80000000` by -1: `32'h80000000`.
  - In all three, `done` is high one cycle after start.
- Accept and abort behaviour:
  - Start with a non-M code (for example ADD): no `busy`.
  - Start while busy: ignored, and the first operation's result is intact.
  - `flush` at CALC count 10: IDLE next cycle, no `done`, `result` equals the prior value.
- Pull `rst_n` low at CALC count 20: all outputs 0 at once. After release, a new DIVU 100/7 returns 14.
